multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
//
// Purpose: adds two arbitrarily long operands streamed as 16-bit words
// (least-significant word first). Carries are chained from word to word
// through a registered carry. Each accepted word produces one result word
// one cycle later on a valid/ready output stage.
//
// Optional feature: define MULTIWORD_SUB_EN to add port in_sub. It is
// sampled on a packet's first word and held for the whole packet. When set,
// the block computes a - b: it feeds ~in_b to the adder and forces the
// first-word carry to 1. In that mode out_cout=1 means "no borrow".
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input word handshake
//   in_a, in_b            16-bit operand words
//   in_cin                packet carry-in (used on first word only)
//   in_first, in_last     packet delimiters (may both be set)
//   in_sub                subtract select (MULTIWORD_SUB_EN builds only)
//   out_valid/out_ready   result word handshake
//   out_sum               16-bit result word
//   out_last              result closes its packet
//   out_cout              packet carry-out, valid with out_last, else 0
//   out_idx               word index within packet, saturating
//   err                   sticky protocol-error flag
// -----------------------------------------------------------------------------

// 16-bit Kogge-Stone parallel-prefix adder. The carry-in is folded into the
// bit-0 generate, so after the prefix tree g_grp[i] is the carry out of bit i.
module prefix_adder (
  input  logic [15:0] term0,
  input  logic [15:0] term1,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p_bit;
  logic [15:0] g_grp;
  logic [15:0] p_grp;
  logic [15:0] carry_in;

  always_comb begin
    p_bit    = term0 ^ term1;
    g_grp    = term0 & term1;
    g_grp[0] = g_grp[0] | (p_bit[0] & cin);
    p_grp    = p_bit;
    // After the level with span d, the low d bits of g_grp already hold
    // final carries, so their shifted-in zero propagate terms are harmless.
    for (int lvl = 0; lvl < 4; lvl++) begin
      g_grp = g_grp | (p_grp & (g_grp << (1 << lvl)));
      p_grp = p_grp & (p_grp << (1 << lvl));
    end
  end

  assign carry_in = {g_grp[14:0], cin};
  assign cout     = g_grp[15];

  for (genvar gi = 0; gi < 16; gi++) begin : g_sum
    assign sum[gi] = p_bit[gi] ^ carry_in[gi];
  end
endmodule

module multiword_add_sequencer #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
`ifdef MULTIWORD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic [IDX_W-1:0] out_idx,
  output logic             err
);
  typedef enum logic {
    IDLE  = 1'b0,
    CHAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [15:0]      sum_q, sum_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic        accept;
  logic        start_pkt;
  logic        proto_err;
  logic        sub_sel;
  logic        cin_sel;
  logic [15:0] b_sel;
  logic [15:0] add_sum;
  logic        add_cout;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Any word arriving in IDLE starts a packet; in_first inside a packet
  // restarts it. Either mismatch with in_first is a protocol error.
  assign start_pkt = (state_q == IDLE) || in_first;
  assign proto_err = (state_q == IDLE) ? !in_first : in_first;

`ifdef MULTIWORD_SUB_EN
  logic sub_q, sub_d;

  assign sub_sel = start_pkt ? in_sub : sub_q;
  // Subtraction is a + ~b + 1, so the first-word carry is forced high.
  assign cin_sel = start_pkt ? (in_sub | in_cin) : carry_q;
  assign sub_d   = (accept && start_pkt) ? in_sub : sub_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`else
  assign sub_sel = 1'b0;
  assign cin_sel = start_pkt ? in_cin : carry_q;
`endif

  assign b_sel = sub_sel ? ~in_b : in_b;

  prefix_adder u_adder (
    .term0 (in_a),
    .term1 (b_sel),
    .cin   (cin_sel),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (accept) begin
      // Loading a new result also covers the case where the previous one
      // is leaving this cycle, so throughput stays at one word per cycle.
      state_d = in_last ? IDLE : CHAIN;
      carry_d = add_cout;
      valid_d = 1'b1;
      sum_d   = add_sum;
      last_d  = in_last;
      cout_d  = in_last & add_cout;
      if (start_pkt) begin
        idx_d = '0;
      end else if (idx_q != IDX_MAX) begin
        idx_d = idx_q + 1'b1;
      end
      err_d = err_q | proto_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign out_idx   = idx_q;
  assign err       = err_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer: directed scenarios with literal
// expectations, followed by randomized traffic compared every cycle against
// an arithmetic reference model.
module tb_multiword_add_sequencer;
  localparam int IDX_W   = 3;
  localparam int IDX_MAX = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_sum;
  logic             out_last;
  logic             out_cout;
  logic [IDX_W-1:0] out_idx;
  logic             err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_first  (in_first),
    .in_last   (in_last),
`ifdef MULTIWORD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_idx   (out_idx),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: a word's value is a + b (or a + (0xFFFF - b) when
  // subtracting) + carry, done as plain integer arithmetic; bit 16 is the carry.
  bit        m_in_pkt, m_carry, m_sub, m_valid, m_last, m_cout, m_err;
  bit [15:0] m_sum;
  int        m_idx;
  bit        m_acc, m_first, m_subsel, m_c, m_perr;
  int        m_total, m_idx_next;

  always_comb begin
    m_acc      = in_valid && (!m_valid || out_ready);
    m_first    = !m_in_pkt || in_first;
    m_perr     = (m_in_pkt == in_first);
    m_subsel   = m_first ? in_sub : m_sub;
    m_c        = m_first ? (in_sub ? 1'b1 : in_cin) : m_carry;
    m_total    = int'(in_a) + (m_subsel ? (65535 - int'(in_b)) : int'(in_b)) + int'(m_c);
    m_idx_next = m_first ? 0 : ((m_idx + 1 > IDX_MAX) ? IDX_MAX : m_idx + 1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_pkt <= 0; m_carry <= 0; m_sub <= 0; m_valid <= 0;
      m_sum <= 0; m_last <= 0; m_cout <= 0; m_idx <= 0; m_err <= 0;
    end else if (m_acc) begin
      m_in_pkt <= !in_last;
      m_carry  <= m_total[16];
      m_sub    <= m_subsel;
      m_valid  <= 1'b1;
      m_sum    <= m_total[15:0];
      m_last   <= in_last;
      m_cout   <= in_last && m_total[16];
      m_idx    <= m_idx_next;
      m_err    <= m_err || m_perr;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready",  in_ready,  !m_valid || out_ready);
      chk("m_out_valid", out_valid, m_valid);
      chk("m_out_sum",   out_sum,   m_sum);
      chk("m_out_last",  out_last,  m_last);
      chk("m_out_cout",  out_cout,  m_cout);
      chk("m_out_idx",   out_idx,   m_idx);
      chk("m_err",       err,       m_err);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_word(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic first, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_first = first; in_last = last;
  endtask

  // Waits for the edge that accepts the presented word, then settles 2 time units.
  task automatic wait_accept();
    int  n   = 0;
    bit  acc = 1'b0;
    while (!acc && n < 50) begin
      @(posedge clk);
      acc = !m_valid || out_ready;
      n++;
    end
    chk("accept_timeout", acc, 1'b1);
    #2;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic first, input logic last);
    set_word(a, b, cin, first, last);
    wait_accept();
  endtask

  task automatic expect_out(input string name, input logic [15:0] sum, input logic cout,
                            input int idx, input logic last);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_sum"},   out_sum,   sum);
    chk({name, "_cout"},  out_cout,  cout);
    chk({name, "_idx"},   out_idx,   idx);
    chk({name, "_last"},  out_last,  last);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, 16'h0000);
    chk("rst_idx", out_idx, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_cout", out_cout, 1'b0);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1'b1);
    idle(1);

    // Single word with wrap-around carry.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    expect_out("single", 16'h0000, 1'b1, 0, 1'b1);
    idle(1);

    // Three words back to back, carry rippling through two words.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    expect_out("three_w0", 16'h0000, 1'b0, 0, 1'b0);
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("three_w1", 16'h0000, 1'b0, 1, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("three_w2", 16'h0001, 1'b0, 2, 1'b1);
    chk("three_err", err, 1'b0);
    idle(1);
    chk("drain_valid", out_valid, 1'b0);

    // Backpressure: result held 3 cycles, next word waits then follows.
    out_ready = 1'b0;
    drive(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
    expect_out("bp_a", 16'h3333, 1'b0, 0, 1'b1);
    set_word(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_sum", out_sum, 16'h3333);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    wait_accept();
    expect_out("bp_b", 16'h0101, 1'b0, 0, 1'b1);
    idle(1);
    chk("bp_drain", out_valid, 1'b0);

    // Index saturation over a 10-word packet.
    for (int i = 0; i < 10; i++) begin
      drive(16'(i), 16'h0000, 1'b0, i == 0, i == 9);
      chk("sat_idx", out_idx, (i > IDX_MAX) ? IDX_MAX : i);
      chk("sat_sum", out_sum, i);
    end
    idle(1);

    // Protocol error: in_first mid-packet restarts with in_cin, not old carry.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("perr_pre_err", err, 1'b0);
    drive(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
    expect_out("perr_restart", 16'h0002, 1'b0, 0, 1'b0);
    chk("perr_err", err, 1'b1);
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_out("perr_tail", 16'hFFFF, 1'b0, 1, 1'b1);
    idle(1);
    drive(16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1);
    expect_out("perr_next", 16'h2346, 1'b0, 0, 1'b1);
    chk("perr_sticky", err, 1'b1);
    idle(1);

    // Reset mid-packet, then a clean packet.
    drive(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_err", err, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    drive(16'h0002, 16'h0003, 1'b1, 1'b1, 1'b1);
    expect_out("postrst", 16'h0006, 1'b0, 0, 1'b1);
    chk("postrst_err", err, 1'b0);
    idle(1);

    // Reset mid-packet, then a word lacking in_first: treated as first, err set.
    drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    drive(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1);
    expect_out("nofirst", 16'h0003, 1'b0, 0, 1'b1);
    chk("nofirst_err", err, 1'b1);
    idle(1);

`ifdef MULTIWORD_SUB_EN
    in_sub = 1'b1;
    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    expect_out("sub", 16'hFFFE, 1'b0, 0, 1'b1);
    in_sub = 1'b0;
    idle(1);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      in_first  = m_in_pkt ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 15) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
`ifdef MULTIWORD_SUB_EN
      in_sub    = 1'($urandom_range(0, 1));
`else
      in_sub    = 1'b0;
`endif
    end
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
